// File: rtl/h2bp_seq_alu.sv
// h2bp_seq_alu: multi-cycle H2BP ALU with valid/ready on both sides.
// MUL is iterative shift-add, DIV is iterative restoring division.
package h2bp;
    typedef enum logic [2:0] {
        opADD, opSUB, opMUL, opDIV,
        opAND, opOR, opLSHIFT, opRSHIFT
    } operations;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } flags;
endpackage

module h2bp_seq_alu
    import h2bp::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output flags             flags_o,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE, MUL_ITER, DIV_ITER, DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] dv;
    logic [SHW-1:0]   cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH:0]   lsh;
    logic [WIDTH:0]   rsh;
    logic [SHW-1:0]   amt;
    logic             big;
    logic             is_mul;
    logic             is_div;
    logic [WIDTH-1:0] s_res;
    logic             s_c;
    logic             s_v;

    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};
    assign amt = b[SHW-1:0];
    assign big = |b[WIDTH-1:SHW];
    // The extra bit on each side catches the last bit shifted out.
    assign lsh = {1'b0, a} << amt;
    assign rsh = {a, 1'b0} >> amt;

    assign is_mul = (operations'(op) == opMUL);
    assign is_div = (operations'(op) == opDIV) && (b != '0);

    always_comb begin
        s_res = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        unique case (operations'(op))
            opADD: begin
                s_res = sum[WIDTH-1:0];
                s_c   = sum[WIDTH];
                s_v   = (a[WIDTH-1] == b[WIDTH-1])
                      && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            opSUB: begin
                s_res = dif[WIDTH-1:0];
                s_c   = dif[WIDTH];
                s_v   = (a[WIDTH-1] != b[WIDTH-1])
                      && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            opMUL: s_res = '0;
            opDIV: begin
                s_res = '1;
                s_v   = 1'b1;
            end
            opAND: s_res = a & b;
            opOR:  s_res = a | b;
            opLSHIFT: begin
                s_res = big ? '0 : lsh[WIDTH-1:0];
                s_c   = big ? 1'b0 : lsh[WIDTH];
            end
            opRSHIFT: begin
                s_res = big ? '0 : rsh[WIDTH:1];
                s_c   = big ? 1'b0 : rsh[0];
            end
        endcase
    end

    logic [WIDTH:0]   madd;
    logic [WIDTH-1:0] m_hi;
    logic [WIDTH-1:0] m_lo;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rdiff;
    logic             ge;
    logic [WIDTH-1:0] d_rem;
    logic [WIDTH-1:0] d_q;
    logic             last;

    assign madd   = {1'b0, hi} + (lo[0] ? {1'b0, dv} : '0);
    assign m_hi   = madd[WIDTH:1];
    assign m_lo   = {madd[0], lo[WIDTH-1:1]};
    // rem < dv keeps rdiff below 2^WIDTH when no borrow occurs.
    assign rem_sh = {hi, lo[WIDTH-1]};
    assign rdiff  = rem_sh - {1'b0, dv};
    assign ge     = !rdiff[WIDTH];
    assign d_rem  = ge ? rdiff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign d_q    = {lo[WIDTH-2:0], ge};
    assign last   = (cnt == SHW'(WIDTH - 1));

    function automatic flags mk(
        input logic [WIDTH-1:0] r,
        input logic             c,
        input logic             v
    );
        flags f;
        f.zero     = (r == '0);
        f.negative = r[WIDTH-1];
        f.carry    = c;
        f.overflow = v;
        return f;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            flags_o   <= '0;
            hi        <= '0;
            lo        <= '0;
            dv        <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        cnt      <= '0;
                        hi       <= '0;
                        unique case (1'b1)
                            is_mul: begin
                                lo    <= b;
                                dv    <= a;
                                busy  <= 1'b1;
                                state <= MUL_ITER;
                            end
                            is_div: begin
                                lo    <= a;
                                dv    <= b;
                                busy  <= 1'b1;
                                state <= DIV_ITER;
                            end
                            default: begin
                                result    <= s_res;
                                flags_o   <= mk(s_res, s_c, s_v);
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                        endcase
                    end
                end
                MUL_ITER: begin
                    hi  <= m_hi;
                    lo  <= m_lo;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result    <= m_lo;
                        flags_o   <= mk(m_lo, |m_hi, |m_hi);
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DIV_ITER: begin
                    hi  <= d_rem;
                    lo  <= d_q;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result    <= d_q;
                        flags_o   <= mk(d_q, 1'b0, 1'b0);
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_h2bp_seq_alu.sv
// Scoreboard bench for h2bp_seq_alu: random and directed ops vs an
// arithmetic reference model, with latency, busy and backpressure checks.
module tb_h2bp_seq_alu;
    import h2bp::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    flags         flags_o;
    logic         busy;

    h2bp_seq_alu #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .flags_o(flags_o),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
        int           acc;
        int           lat;
        int           bsy;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic hold = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask

    // Reference: plain wide arithmetic on the operation definitions.
    function automatic void ref_model(
        input  logic [2:0]   o,
        input  logic [W-1:0] x,
        input  logic [W-1:0] y,
        output logic [W-1:0] r,
        output logic [3:0]   f
    );
        longint          sx  = longint'($signed(x));
        longint          sy  = longint'($signed(y));
        longint          lim = longint'(1) << (W - 1);
        longint          s;
        longint unsigned ux  = 64'(x);
        longint unsigned uy  = 64'(y);
        longint unsigned p;
        logic            c   = 1'b0;
        logic            v   = 1'b0;
        r = '0;
        case (o)
            opADD: begin
                p = ux + uy;
                r = p[W-1:0];
                c = p[W];
                s = sx + sy;
                v = (s >= lim) || (s < -lim);
            end
            opSUB: begin
                r = x - y;
                c = ux < uy;
                s = sx - sy;
                v = (s >= lim) || (s < -lim);
            end
            opMUL: begin
                p = ux * uy;
                r = p[W-1:0];
                c = (p >> W) != 0;
                v = c;
            end
            opDIV: begin
                if (uy == 0) begin
                    r = '1;
                    v = 1'b1;
                end else begin
                    p = ux / uy;
                    r = p[W-1:0];
                end
            end
            opAND: r = x & y;
            opOR:  r = x | y;
            opLSHIFT: begin
                if (uy < W) begin
                    p = ux << uy;
                    r = p[W-1:0];
                    c = p[W];
                end
            end
            default: begin
                if (uy < W) begin
                    p = (ux << W) >> uy;
                    r = p[2*W-1:W];
                    c = p[W-1];
                end
            end
        endcase
        f = {r == '0, r[W-1], c, v};
    endfunction

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        exp_t e;
        int   g = 0;
        bit   iter;
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        while (!in_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            timeout("in_ready_wait");
            in_valid = 1'b0;
            return;
        end
        iter = (o == opMUL) || (o == opDIV && y != '0);
        ref_model(o, x, y, e.res, e.flg);
        e.acc = cyc + 1;
        e.lat = iter ? W + 1 : 1;
        e.bsy = iter ? W : 0;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op = 3'($urandom);
        a  = $urandom;
        b  = $urandom;
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) timeout("drain");
    endtask

    int           bcnt = 0;
    bit           seen = 1'b0;
    int           first_cyc = 0;
    logic [W-1:0] hres;
    logic [3:0]   hflg;
    exp_t         em;

    always @(negedge clk) begin
        if (rst) begin
            bcnt = 0;
            seen = 1'b0;
            out_ready = 1'b0;
        end else begin
            if (busy) begin
                bcnt++;
                chk("in_ready_busy", in_ready, 0);
            end
            if (out_valid) begin
                chk("in_ready_done", in_ready, 0);
                if (!seen) begin
                    seen = 1'b1;
                    first_cyc = cyc;
                    hres = result;
                    hflg = flags_o;
                end else begin
                    chk("stable_result", result, hres);
                    chk("stable_flags", flags_o, hflg);
                end
                out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        timeout("unexpected_output");
                    end else begin
                        em = sb.pop_front();
                        chk("result", result, em.res);
                        chk("flags", flags_o, em.flg);
                        chk("latency", first_cyc + 1 - em.acc, em.lat);
                        chk("busy_cycles", bcnt, em.bsy);
                    end
                    bcnt = 0;
                    seen = 1'b0;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst = 1'b1;
        in_valid = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags_o, 0);
        rst = 1'b0;
        @(negedge clk);

        issue(opADD, 32'hFFFF_FFFF, 32'd1);
        issue(opADD, 32'h7FFF_FFFF, 32'd1);
        issue(opSUB, 32'd3, 32'd5);
        issue(opMUL, 32'h0001_0000, 32'h0001_0000);
        issue(opMUL, 32'd7, 32'd6);
        issue(opDIV, 32'd100, 32'd7);
        issue(opDIV, 32'd5, 32'd0);
        issue(opLSHIFT, 32'h8000_0001, 32'd1);
        issue(opRSHIFT, 32'h0000_00F0, 32'd36);
        issue(opRSHIFT, 32'h0000_00F1, 32'd1);
        issue(opLSHIFT, 32'h1234_5678, 32'd0);
        issue(opSUB, 32'h8000_0000, 32'd1);
        drain();

        hold = 1'b1;
        issue(opADD, 32'h1111_1111, 32'h2222_2222);
        repeat (10) @(negedge clk);
        chk("hold_out_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        hold = 1'b0;
        drain();

        issue(opMUL, 32'h0001_2345, 32'h0000_6789);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_result", result, 0);
        chk("abort_flags", flags_o, 0);
        issue(opADD, 32'd2, 32'd2);
        drain();

        for (int i = 0; i < 250; i++) begin
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: ra = '0;
                1: ra = '1;
                2: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case (ro)
                opLSHIFT, opRSHIFT: rb = W'($urandom_range(0, 40));
                opDIV: rb = ($urandom_range(0, 4) == 0) ? '0
                          : W'($urandom_range(1, 1000));
                opMUL: rb = ($urandom_range(0, 1) == 0) ? $urandom
                          : W'($urandom_range(0, 255));
                default: rb = ($urandom_range(0, 5) == 0) ? '1 : $urandom;
            endcase
            issue(ro, ra, rb);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
